// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the register file, decode and the write-back controller.
//   XLEN     - integer data width
//   NREG     - number of architectural registers
//   REG_AW   - register address width
//   REG_ZERO - address of the hardwired-zero register
//   wb_src_e - identifies which write-back producer was granted
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_rr_arb.sv
// wb_rr_arb: two-requester round-robin arbiter for the register-file write port.
//   clk, reset         - clock, synchronous active-high reset
//   alu_req, lsu_req   - producer requests (their valids)
//   alu_gnt, lsu_gnt   - one-hot-or-zero grants, combinational from requests and pointer
module wb_rr_arb
    import riscv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic alu_req,
    input  logic lsu_req,
    output logic alu_gnt,
    output logic lsu_gnt
);

    wb_src_e last;

    // On a tie the unit that was not granted last time wins.
    always_comb begin
        alu_gnt = alu_req && (!lsu_req || last == GNT_LSU);
        lsu_gnt = lsu_req && (!alu_req || last == GNT_ALU);
    end

    // Pointer starts at LSU so the ALU wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            last <= GNT_LSU;
        else if (alu_gnt)
            last <= GNT_ALU;
        else if (lsu_gnt)
            last <= GNT_LSU;
    end

endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: write-side controller of the integer register file.
//   clk, reset                       - clock, synchronous active-high reset
//   iss_valid, iss_rd                - decode issues a writer of iss_rd (marks it busy)
//   alu_valid/ready/rd/data          - ALU result handshake
//   lsu_valid/ready/rd/data          - load result handshake
//   wr_en, wr_addr, wr_data          - registered register-file write port
//   rs1, rs2                         - decode source addresses
//   rs1_busy, rs2_busy               - source has a pending write not yet visible
//   rs1_fwd, rs2_fwd, fwd_data       - source is being written this cycle, with its value
module regfile_writer
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NREG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [$clog2(NREG)-1:0] alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [$clog2(NREG)-1:0] lsu_rd,
    input  logic [XLEN-1:0]         lsu_data,
    output logic                    wr_en,
    output logic [$clog2(NREG)-1:0] wr_addr,
    output logic [XLEN-1:0]         wr_data,
    input  logic [$clog2(NREG)-1:0] rs1,
    input  logic [$clog2(NREG)-1:0] rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    rs1_fwd,
    output logic                    rs2_fwd,
    output logic [XLEN-1:0]         fwd_data
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    wb_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .alu_req (alu_valid),
        .lsu_req (lsu_valid),
        .alu_gnt (alu_ready),
        .lsu_gnt (lsu_ready)
    );

    always_comb begin
        xfer     = alu_ready || lsu_ready;
        sel_rd   = alu_ready ? alu_rd : lsu_rd;
        sel_data = alu_ready ? alu_data : lsu_data;
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= xfer && sel_rd != ZERO;
            if (xfer) begin
                wr_addr <= sel_rd;
                wr_data <= sel_data;
            end
        end
    end

    // Set is applied after clear: a same-edge issue is a younger writer still pending.
    always_comb begin
        busy_next = busy;
        if (wr_en)
            busy_next[wr_addr] = 1'b0;
        if (iss_valid && iss_rd != ZERO)
            busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // A register written this cycle is forwarded rather than reported busy.
    always_comb begin
        rs1_fwd  = wr_en && wr_addr == rs1 && rs1 != ZERO;
        rs2_fwd  = wr_en && wr_addr == rs2 && rs2 != ZERO;
        rs1_busy = busy[rs1] && !rs1_fwd;
        rs2_busy = busy[rs2] && !rs2_fwd;
        fwd_data = wr_data;
    end

endmodule

// File: tb/tb_regfile_writer.sv
module tb_regfile_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of pending writes and the output slot.
    bit          m_busy [32];
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_alu_won_last;
    bit          g_alu, g_lsu;

    always #5 clk = ~clk;

    regfile_writer dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .fwd_data(fwd_data)
    );

    function automatic void pick(output bit ga, output bit gl);
        if (alu_valid && lsu_valid) begin
            ga = !m_alu_won_last;
            gl = m_alu_won_last;
        end else begin
            ga = alu_valid;
            gl = lsu_valid;
        end
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        pick(g_alu, g_lsu);
        @(posedge clk);
        if (reset) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_wen = 0;
            m_waddr = 0;
            m_wdata = 0;
            m_alu_won_last = 0;
        end else begin
            if (m_wen) m_busy[m_waddr] = 0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
            m_wen = 0;
            if (g_alu) begin
                m_wen = alu_rd != 0; m_waddr = alu_rd; m_wdata = alu_data; m_alu_won_last = 1;
            end else if (g_lsu) begin
                m_wen = lsu_rd != 0; m_waddr = lsu_rd; m_wdata = lsu_data; m_alu_won_last = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
        checks++; if (fwd_data !== 32'd0) begin errors++; $display("FAIL reset_fwd_data got %h exp 0", fwd_data); end
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); rs2 = 5'(31 - r);
            #1;
            checks++;
            if ({rs1_busy, rs2_busy, rs1_fwd, rs2_fwd} !== 4'b0) begin
                errors++; $display("FAIL reset_query r=%0d got %b exp 0000", r, {rs1_busy, rs2_busy, rs1_fwd, rs2_fwd});
            end
        end
        alu_valid = 1; lsu_valid = 0;
        #1;
        checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 10", alu_ready, lsu_ready); end
        alu_valid = 0;
    endtask

    task automatic test_single_alu();
        do_reset();
        iss_valid = 1; iss_rd = 5;
        tick();
        iss_valid = 0; rs1 = 5;
        #1;
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL single_busy_before got %b exp 1", rs1_busy); end
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %b exp 1", alu_ready); end
        tick();
        alu_valid = 0;
        #1;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5) begin errors++; $display("FAIL single_write got en=%b addr=%0d exp en=1 addr=5", wr_en, wr_addr); end
        checks++; if (wr_data !== 32'hDEADBEEF || fwd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h/%h exp deadbeef", wr_data, fwd_data); end
        checks++; if (rs1_fwd !== 1'b1 || rs1_busy !== 1'b0) begin errors++; $display("FAIL single_fwd got fwd=%b busy=%b exp fwd=1 busy=0", rs1_fwd, rs1_busy); end
        tick();
        checks++; if (rs1_busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL single_cleared got busy=%b en=%b exp 0 0", rs1_busy, wr_en); end
    endtask

    task automatic test_contention();
        int na = 0, nl = 0;
        do_reset();
        alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 2;
        for (int k = 0; k < 4; k++) begin
            bit exp_alu = (k % 2) == 0;
            alu_data = 32'hA000_0000 + 32'(na);
            lsu_data = 32'hB000_0000 + 32'(nl);
            #1;
            checks++;
            if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
                errors++; $display("FAIL contention_grant k=%0d got %b%b exp %b%b", k, alu_ready, lsu_ready, exp_alu, !exp_alu);
            end
            tick();
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== (exp_alu ? 5'd1 : 5'd2) ||
                wr_data !== (exp_alu ? 32'hA000_0000 + 32'(na) : 32'hB000_0000 + 32'(nl))) begin
                errors++; $display("FAIL contention_write k=%0d got en=%b addr=%0d data=%h", k, wr_en, wr_addr, wr_data);
            end
            if (exp_alu) na++; else nl++;
        end
        idle_inputs();
    endtask

    task automatic test_x0_drop();
        do_reset();
        iss_valid = 1; iss_rd = 9;
        tick();
        iss_valid = 0;
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", lsu_ready); end
        tick();
        lsu_valid = 0; rs1 = 9; rs2 = 0;
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL x0_wr_en got %b exp 0", wr_en); end
        checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0 || rs2_fwd !== 1'b0) begin errors++; $display("FAIL x0_busy got %b%b%b exp 100", rs1_busy, rs2_busy, rs2_fwd); end
        tick();
        checks++; if (wr_en !== 1'b0 || rs1_busy !== 1'b1) begin errors++; $display("FAIL x0_after got en=%b busy=%b exp 0 1", wr_en, rs1_busy); end
    endtask

    task automatic test_collision();
        do_reset();
        iss_valid = 1; iss_rd = 7;
        tick();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h7777_0007;
        tick();
        alu_valid = 0;
        iss_valid = 1; iss_rd = 7; rs1 = 7;
        #1;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || rs1_fwd !== 1'b1) begin errors++; $display("FAIL collide_write got en=%b addr=%0d fwd=%b", wr_en, wr_addr, rs1_fwd); end
        tick();
        iss_valid = 0;
        #1;
        checks++; if (rs1_busy !== 1'b1 || rs1_fwd !== 1'b0) begin errors++; $display("FAIL collide_busy got busy=%b fwd=%b exp 1 0", rs1_busy, rs1_fwd); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        iss_valid = 1; iss_rd = 3;
        tick();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h3333_3333;
        tick();
        alu_valid = 0;
        reset = 1;
        tick();
        rs1 = 3;
        #1;
        checks++; if (wr_en !== 1'b0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL midreset_a got en=%b busy=%b exp 0 0", wr_en, rs1_busy); end
        reset = 0;
        iss_valid = 1; iss_rd = 3;
        tick();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h4444_4444;
        reset = 1;
        tick();
        alu_valid = 0; reset = 0;
        #1;
        checks++; if (wr_en !== 1'b0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL midreset_b got en=%b busy=%b exp 0 0", wr_en, rs1_busy); end
        tick();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midreset_c got en=%b exp 0", wr_en); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            bit ea, el, f1, f2;
            if (!alu_valid || g_alu) begin
                alu_valid = ($urandom % 3) != 0;
                alu_rd = 5'($urandom);
                alu_data = $urandom;
            end
            if (!lsu_valid || g_lsu) begin
                lsu_valid = ($urandom % 3) != 0;
                lsu_rd = 5'($urandom);
                lsu_data = $urandom;
            end
            iss_valid = ($urandom % 2) != 0;
            iss_rd = 5'($urandom);
            rs1 = ($urandom % 2) ? m_waddr : 5'($urandom);
            rs2 = ($urandom % 4) == 0 ? 5'd0 : 5'($urandom);
            reset = ($urandom % 100) == 0;
            #1;
            pick(ea, el);
            f1 = m_wen && m_waddr == rs1 && rs1 != 0;
            f2 = m_wen && m_waddr == rs2 && rs2 != 0;
            checks++;
            if (alu_ready !== ea || lsu_ready !== el) begin
                errors++; $display("FAIL rand_ready c=%0d got %b%b exp %b%b", c, alu_ready, lsu_ready, ea, el);
            end
            checks++;
            if (wr_en !== m_wen || wr_addr !== m_waddr || wr_data !== m_wdata || fwd_data !== m_wdata) begin
                errors++; $display("FAIL rand_write c=%0d got %b/%0d/%h exp %b/%0d/%h", c, wr_en, wr_addr, wr_data, m_wen, m_waddr, m_wdata);
            end
            checks++;
            if (rs1_fwd !== f1 || rs2_fwd !== f2 ||
                rs1_busy !== (m_busy[rs1] && !f1) || rs2_busy !== (m_busy[rs2] && !f2)) begin
                errors++; $display("FAIL rand_query c=%0d rs1=%0d rs2=%0d got %b%b%b%b exp %b%b%b%b", c, rs1, rs2,
                    rs1_fwd, rs2_fwd, rs1_busy, rs2_busy, f1, f2, m_busy[rs1] && !f1, m_busy[rs2] && !f2);
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        m_alu_won_last = 0;
        test_reset();
        test_single_alu();
        test_contention();
        test_x0_drop();
        test_collision();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writer.md
# regfile_writer

Write-side controller for the 32×32 integer register file. It arbitrates completed results from the ALU and load/store unit into the single register-file write port, and tracks outstanding destination registers in a busy scoreboard so decode can stall on read-after-write hazards. It also forwards the in-flight write to the two read ports so decode never reads stale data.

## Interface
Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; the address width is log2(NREG).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- iss_valid  in  1  decode issues an instruction that writes rd.
- iss_rd  in  5  destination register of the issued instruction.
- alu_valid  in  1  ALU result available.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result available.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd  in  5  load destination register.
- lsu_data  in  XLEN  load result.
- wr_en  out  1  register-file write enable.
- wr_addr  out  5  register-file write address.
- wr_data  out  XLEN  register-file write data.
- rs1, rs2  in  5 each  decode read addresses.
- rs1_busy, rs2_busy  out  1 each  source register has a pending write not yet visible.
- rs1_fwd, rs2_fwd  out  1 each  the current wr_en write targets this source register.
- fwd_data  out  XLEN  equals wr_data, for use in the bypass mux.

## Operation
- **Handshake:** a producer holds valid, rd and data stable until ready. A transfer occurs on any cycle where valid && ready.
- **Arbitration:** one grant per cycle, round-robin between ALU and LSU.
  - With a single requester, that requester is granted.
  - With both requesting, the unit not granted last time wins.
  - The last-grant pointer resets to LSU, so ALU wins the first tie.
  - ready is combinational from the valids and the pointer. The output stage never back-pressures because the register file always accepts a write.
- **Output register:** an accepted transfer loads wr_addr and wr_data, and sets wr_en for exactly the next cycle.
  - A transfer with rd==0 is consumed (ready=1) but produces wr_en=0.
  - With no transfer, wr_en=0 and wr_addr/wr_data hold their previous values.
- **Scoreboard:** a busy[NREG] vector.
  - Set: iss_valid && iss_rd!=0 sets busy[iss_rd] at the clock edge.
  - Clear: busy[wr_addr] is cleared at the edge ending a wr_en=1 cycle.
  - Set and clear to the same register at the same edge: set wins, because a younger writer is pending.
  - busy[0] is constant 0.
- **Queries:**
  - rsN_fwd = wr_en && wr_addr==rsN && rsN!=0.
  - rsN_busy = busy[rsN] && !rsN_fwd.
  - Decode stalls on busy and muxes fwd_data on fwd.
- **Ordering:** the block does not reorder producers. Decode must not issue a second writer to a register still marked busy.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0.
  - busy all 0.
  - last-grant pointer = LSU.
  - All *_busy and *_fwd outputs are 0 and fwd_data=0.
  - alu_ready/lsu_ready follow the valids combinationally.
- Latency: a transfer at cycle N gives wr_en at N+1, and the register file holds the value from edge N+2. busy clears at the same edge.
- Issue at edge E: rs*_busy reads 1 from the cycle after E.
- Reset asserted mid-operation: a pending output write is dropped (wr_en=0 next cycle), busy is cleared, and the pointer is restored. Producers must not rely on results accepted in the reset cycle.
- There are no combinational paths from producer data to wr_* outputs. Ready depends only on the valids and the pointer.

## Structure
- Shared package riscv_pkg holds XLEN, NREG, REG_AW=5, and the constant REG_ZERO=0. The same constants are used by the register file and decode.
- One sub-module: wb_rr_arb, a 2-requester round-robin arbiter with its grant pointer.
- The scoreboard and output register stay in the top module.

## Test plan
- **Reset:** reset for 2 cycles → wr_en=0, wr_addr=0, wr_data=0, all busy outputs 0.
- **Single ALU write:** iss rd=5, then alu_valid with rd=5, data=0xDEADBEEF at cycle N.
  - Expect rs1_busy=1 (rs1=5) before N.
  - Expect alu_ready=1 at N.
  - At N+1: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rs1_fwd=1, rs1_busy=0.
  - At N+2: busy[5]=0.
- **Contention:** alu and lsu both valid for 4 cycles (rd=1/2) → grants go ALU, LSU, ALU, LSU, each with wr_en the following cycle with the matching data.
- **x0 drop:** lsu_valid rd=0, data=0x1234 → lsu_ready=1, wr_en stays 0, busy unchanged.
- **Set/clear collision:** register 7 is busy and being written (wr_en, wr_addr=7) while iss_valid with iss_rd=7 → busy[7] remains 1 after the edge.
- **Reset mid-flight:** accept an ALU rd=3 write, then assert reset in the next cycle → wr_en=0 during and after reset, busy[3]=0.
